// File: rtl/mc_control_seq_if.sv
// Instruction-fetch handshake and datapath control bundle between the
// sequencer (master) and the instruction memory / datapath (slave).
interface mc_control_seq_if;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        zero;
   logic [31:0] instruction;
   logic        RegDst;
   logic        RegWrite;
   logic        ALUSrc;
   logic        MemWrite;
   logic        MemRead;
   logic        MemToReg;
   logic [3:0]  ALUcontrol;

   modport master (
      output imem_addr, imem_req, instruction,
      output RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, ALUcontrol,
      input  imem_ack, imem_rdata, zero
   );

   modport slave (
      input  imem_addr, imem_req, instruction,
      input  RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, ALUcontrol,
      output imem_ack, imem_rdata, zero
   );
endinterface

// File: rtl/mc_control_seq.sv
// Multi-cycle sequencer: fetches one word per instruction, latches it in IR and
// steps the datapath controls phase by phase so each write lands in one cycle.
module mc_control_seq #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   run,
   mc_control_seq_if.master       bus,
   output logic [31:0]            pc,
   output logic                   halted,
   output logic [15:0]            retired
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [31:0] ir_r;
   logic [31:0] pc_r;
   logic [15:0] retired_r;
   logic        halted_r;

   logic [5:0]  opcode_s;
   logic [5:0]  funct_s;
   logic        is_rtype_s;
   logic        is_lw_s;
   logic        is_sw_s;
   logic        is_beq_s;
   logic        legal_s;
   logic [3:0]  alu_op_s;
   logic        boundary_s;
   logic        take_s;
   logic [31:0] pc_inc_s;
   logic [31:0] branch_off_s;
   logic [31:0] pc_next_s;
   logic        in_instr_s;
   logic        fetch_s;
   state_t      after_s;

   assign opcode_s = ir_r[31:26];
   assign funct_s  = ir_r[5:0];

   // Instruction class and ALU operation from the latched IR
   always_comb begin
      is_rtype_s = 1'b0;
      is_lw_s    = 1'b0;
      is_sw_s    = 1'b0;
      is_beq_s   = 1'b0;
      alu_op_s   = 4'b0000;
      case (opcode_s)
         6'h00: begin
            case (funct_s)
               6'h20: begin is_rtype_s = 1'b1; alu_op_s = 4'b0101; end
               6'h22: begin is_rtype_s = 1'b1; alu_op_s = 4'b0110; end
               6'h24: begin is_rtype_s = 1'b1; alu_op_s = 4'b0000; end
               6'h25: begin is_rtype_s = 1'b1; alu_op_s = 4'b0001; end
               6'h2A: begin is_rtype_s = 1'b1; alu_op_s = 4'b0111; end
               default: begin is_rtype_s = 1'b0; alu_op_s = 4'b0000; end
            endcase
         end
         6'h23:   begin is_lw_s  = 1'b1; alu_op_s = 4'b0101; end
         6'h2B:   begin is_sw_s  = 1'b1; alu_op_s = 4'b0101; end
         6'h04:   begin is_beq_s = 1'b1; alu_op_s = 4'b0110; end
         default: begin alu_op_s = 4'b0000; end
      endcase
   end

   assign legal_s = is_rtype_s | is_lw_s | is_sw_s | is_beq_s;
   assign after_s = run ? ST_FETCH : ST_IDLE;

   // The last phase of every legal instruction is where pc and retired advance
   assign boundary_s = ((state_r == ST_EXEC) & is_beq_s) |
                       ((state_r == ST_MEM)  & is_sw_s)  |
                       (state_r == ST_WB);

   assign take_s       = (state_r == ST_EXEC) & is_beq_s & bus.zero;
   assign pc_inc_s     = pc_r + 32'd4;
   assign branch_off_s = {{14{ir_r[15]}}, ir_r[15:0], 2'b00};
   assign pc_next_s    = take_s ? (pc_inc_s + branch_off_s) : pc_inc_s;

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (run) state_s = ST_FETCH;
            else     state_s = ST_IDLE;
         end
         ST_FETCH: begin
            if (bus.imem_ack) state_s = ST_DECODE;
            else              state_s = ST_FETCH;
         end
         ST_DECODE: begin
            if (legal_s) state_s = ST_EXEC;
            else         state_s = ST_HALT;
         end
         ST_EXEC: begin
            if (is_rtype_s)             state_s = ST_WB;
            else if (is_lw_s | is_sw_s) state_s = ST_MEM;
            else                        state_s = after_s;
         end
         ST_MEM: begin
            if (is_lw_s) state_s = ST_WB;
            else         state_s = after_s;
         end
         ST_WB:   state_s = after_s;
         ST_HALT: state_s = ST_HALT;
         default: state_s = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= ST_IDLE;
      else        state_r <= state_s;
   end

   // IR capture, pc/retired update at the boundary, sticky illegal flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_r      <= 32'h0000_0000;
         pc_r      <= RESET_PC;
         retired_r <= 16'h0000;
         halted_r  <= 1'b0;
      end else begin
         if ((state_r == ST_FETCH) && bus.imem_ack) ir_r <= bus.imem_rdata;
         if (boundary_s) begin
            pc_r      <= pc_next_s;
            retired_r <= retired_r + 16'd1;
         end
         if ((state_r == ST_DECODE) && !legal_s) halted_r <= 1'b1;
      end
   end

   assign in_instr_s = (state_r == ST_DECODE) | (state_r == ST_EXEC) |
                       (state_r == ST_MEM)    | (state_r == ST_WB);
   assign fetch_s    = (state_r == ST_FETCH);

   assign bus.imem_req   = fetch_s;
   assign bus.imem_addr  = pc_r;
   assign bus.instruction = ir_r;
   assign bus.RegDst     = in_instr_s & is_rtype_s;
   assign bus.ALUSrc     = in_instr_s & (is_lw_s | is_sw_s);
   assign bus.MemToReg   = in_instr_s & is_lw_s;
   assign bus.ALUcontrol = in_instr_s ? alu_op_s : 4'b0000;
   assign bus.RegWrite   = (state_r == ST_WB) & (is_rtype_s | is_lw_s);
   assign bus.MemWrite   = (state_r == ST_MEM) & is_sw_s;
   assign bus.MemRead    = ((state_r == ST_MEM) | (state_r == ST_WB)) & is_lw_s;

   assign pc      = pc_r;
   assign halted  = halted_r;
   assign retired = retired_r;

endmodule

// File: tb/tb_mc_control_seq.sv
// Scoreboard bench for mc_control_seq: expectations are queued when an
// instruction is issued and compared when the DUT retires it.
module tb_mc_control_seq;

   localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_ILL = 4;

   typedef struct {
      logic [31:0] pc;
      logic [15:0] ret;
      int          cyc, req, regw, memw, memr, regdst, alusrc, memtoreg;
      logic [3:0]  alu;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_a_n, rst_b_n, run, ack, zero_in, sel;
   logic [31:0] rdata;
   logic [31:0] pc1, pc2;
   logic        h1, h2;
   logic [15:0] r1, r2;

   logic [31:0] obs_pc, obs_addr, obs_ir;
   logic        obs_req, obs_halt;
   logic [15:0] obs_ret;
   logic [5:0]  obs_ctl;
   logic [3:0]  obs_alu;

   int          checks = 0;
   int          failures = 0;
   exp_t        sb_q[$];
   logic [31:0] mpc [2];
   logic [15:0] mret [2];

   mc_control_seq_if b1 ();
   mc_control_seq_if b2 ();

   assign b1.imem_ack   = ack & ~sel;
   assign b2.imem_ack   = ack & sel;
   assign b1.imem_rdata = rdata;
   assign b2.imem_rdata = rdata;
   assign b1.zero       = zero_in;
   assign b2.zero       = zero_in;

   mc_control_seq u_dut_a (
      .clk(clk), .rst_n(rst_a_n), .run(run & ~sel), .bus(b1),
      .pc(pc1), .halted(h1), .retired(r1));

   mc_control_seq #(.RESET_PC(32'hFFFF_FFFC)) u_dut_b (
      .clk(clk), .rst_n(rst_b_n), .run(run & sel), .bus(b2),
      .pc(pc2), .halted(h2), .retired(r2));

   always #5 clk = ~clk;

   always_comb begin
      if (sel) begin
         obs_pc = pc2; obs_addr = b2.imem_addr; obs_ir = b2.instruction;
         obs_req = b2.imem_req; obs_halt = h2; obs_ret = r2;
         obs_ctl = {b2.RegDst, b2.RegWrite, b2.ALUSrc, b2.MemWrite, b2.MemRead, b2.MemToReg};
         obs_alu = b2.ALUcontrol;
      end else begin
         obs_pc = pc1; obs_addr = b1.imem_addr; obs_ir = b1.instruction;
         obs_req = b1.imem_req; obs_halt = h1; obs_ret = r1;
         obs_ctl = {b1.RegDst, b1.RegWrite, b1.ALUSrc, b1.MemWrite, b1.MemRead, b1.MemToReg};
         obs_alu = b1.ALUcontrol;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int kind_of(input logic [31:0] w);
      logic [5:0] f;
      f = w[5:0];
      case (w[31:26])
         6'h00:   kind_of = (f == 6'h20 || f == 6'h22 || f == 6'h24 ||
                             f == 6'h25 || f == 6'h2A) ? K_R : K_ILL;
         6'h23:   kind_of = K_LW;
         6'h2B:   kind_of = K_SW;
         6'h04:   kind_of = K_BEQ;
         default: kind_of = K_ILL;
      endcase
   endfunction

   function automatic logic [3:0] alu_of(input logic [31:0] w);
      case (kind_of(w))
         K_R: begin
            case (w[5:0])
               6'h20:   alu_of = 4'b0101;
               6'h22:   alu_of = 4'b0110;
               6'h24:   alu_of = 4'b0000;
               6'h25:   alu_of = 4'b0001;
               default: alu_of = 4'b0111;
            endcase
         end
         K_BEQ:   alu_of = 4'b0110;
         K_ILL:   alu_of = 4'b0000;
         default: alu_of = 4'b0101;
      endcase
   endfunction

   // Issue one instruction on the selected DUT; abort_at>0 pulses reset after that active cycle
   task automatic do_instr(input logic [31:0] word, input int delay, input logic z, input int abort_at);
      exp_t        e;
      exp_t        got;
      int          k, base, waited, cyc;
      logic        started, done;
      logic [15:0] ret0;
      logic [31:0] cur_pc, sext;
      logic [3:0]  alu_last;
      k      = kind_of(word);
      cur_pc = mpc[sel];
      base   = (k == K_BEQ) ? 3 : (k == K_LW) ? 5 : 4;
      sext   = {{14{word[15]}}, word[15:0], 2'b00};
      e.pc   = (k == K_BEQ && z) ? cur_pc + 32'd4 + sext : cur_pc + 32'd4;
      e.ret  = mret[sel] + 16'd1;
      e.cyc  = base + delay;
      e.req  = delay + 1;
      e.regw = (k == K_R || k == K_LW) ? 1 : 0;
      e.memw = (k == K_SW) ? 1 : 0;
      e.memr = (k == K_LW) ? 2 : 0;
      e.regdst   = (k == K_R) ? base - 1 : 0;
      e.alusrc   = (k == K_LW || k == K_SW) ? base - 1 : 0;
      e.memtoreg = (k == K_LW) ? base - 1 : 0;
      e.alu  = alu_of(word);
      if (k != K_ILL && abort_at == 0) begin
         sb_q.push_back(e);
         mpc[sel]  = e.pc;
         mret[sel] = e.ret;
      end
      got = '{pc: 32'h0, ret: 16'h0, cyc: 0, req: 0, regw: 0, memw: 0, memr: 0,
              regdst: 0, alusrc: 0, memtoreg: 0, alu: 4'h0};
      zero_in = z;
      ret0 = obs_ret; started = 1'b0; done = 1'b0; waited = 0; cyc = 0; alu_last = 4'h0;
      @(negedge clk);
      run = 1'b1;
      for (int t = 0; t < 40 && !done; t++) begin
         @(negedge clk);
         if (obs_ret != ret0 || obs_halt) begin
            done = 1'b1;
         end else if (started || obs_req) begin
            if (!started) begin
               started = 1'b1;
               run = 1'b0;
               check_val("fetch_addr", obs_addr, cur_pc);
            end
            cyc++;
            got.req  += int'(obs_req);
            got.regdst += int'(obs_ctl[5]);
            got.regw += int'(obs_ctl[4]);
            got.alusrc += int'(obs_ctl[3]);
            got.memw += int'(obs_ctl[2]);
            got.memr += int'(obs_ctl[1]);
            got.memtoreg += int'(obs_ctl[0]);
            if (!obs_req) alu_last = obs_alu;
            if (obs_req && waited == delay) begin
               ack = 1'b1; rdata = word;
            end else begin
               ack = 1'b0; rdata = 32'hFFFF_FFFF;
               if (obs_req) waited++;
            end
            if (abort_at != 0 && cyc == abort_at) begin
               @(posedge clk);
               #1;
               if (sel) rst_b_n = 1'b0; else rst_a_n = 1'b0;
               for (int j = 0; j < 3; j++) begin
                  @(negedge clk);
                  check_val("abort_ctl", {26'h0, obs_ctl}, 32'h0);
                  check_val("abort_req", {31'h0, obs_req}, 32'h0);
               end
               check_val("abort_ret", {16'h0, obs_ret}, 32'h0);
               check_val("abort_pc", obs_pc, sel ? 32'hFFFF_FFFC : 32'h0);
               rst_b_n = 1'b1; rst_a_n = 1'b1;
               mpc[sel] = sel ? 32'hFFFF_FFFC : 32'h0;
               mret[sel] = 16'h0;
               done = 1'b1;
               abort_at = -1;
            end
         end
      end
      ack = 1'b0;
      check_val("completed", {31'h0, done}, 32'h1);
      if (done && abort_at == 0 && k != K_ILL && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_val("pc_after",  obs_pc, e.pc);
         check_val("retired",   {16'h0, obs_ret}, {16'h0, e.ret});
         check_val("cycles",    cyc, e.cyc);
         check_val("req_cyc",   got.req, e.req);
         check_val("regwrite",  got.regw, e.regw);
         check_val("memwrite",  got.memw, e.memw);
         check_val("memread",   got.memr, e.memr);
         check_val("regdst",    got.regdst, e.regdst);
         check_val("alusrc",    got.alusrc, e.alusrc);
         check_val("memtoreg",  got.memtoreg, e.memtoreg);
         check_val("alucontrol", {28'h0, alu_last}, {28'h0, e.alu});
         check_val("ir", obs_ir, word);
      end
   endtask

   initial begin
      int   bad;
      logic [31:0] rops [4];
      rops[0] = 32'h0043_0822; rops[1] = 32'h0043_0824;
      rops[2] = 32'h0043_0825; rops[3] = 32'h0043_082A;
      rst_a_n = 1'b0; rst_b_n = 1'b0; run = 1'b0; ack = 1'b0; sel = 1'b0;
      rdata = 32'h0; zero_in = 1'b0;
      mpc[0] = 32'h0; mpc[1] = 32'hFFFF_FFFC; mret[0] = 16'h0; mret[1] = 16'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_a_n = 1'b1; rst_b_n = 1'b1;
      repeat (10) @(negedge clk);
      check_val("rst_pc",  obs_pc, 32'h0);
      check_val("rst_req", {31'h0, obs_req}, 32'h0);
      check_val("rst_ctl", {22'h0, obs_alu, obs_ctl}, 32'h0);
      check_val("rst_ret", {16'h0, obs_ret}, 32'h0);
      check_val("rst_ir",  obs_ir, 32'h0);
      check_val("rst_halt", {31'h0, obs_halt}, 32'h0);

      do_instr(32'h0043_0820, 0, 1'b0, 0);     // add, pc 0 -> 4
      // ack while idle must not disturb IR
      @(negedge clk); ack = 1'b1; rdata = 32'hDEAD_BEEF;
      repeat (2) @(negedge clk);
      ack = 1'b0;
      check_val("ack_idle_ir", obs_ir, 32'h0043_0820);
      do_instr(32'h8C44_0000, 2, 1'b0, 0);     // lw, pc 4 -> 8
      do_instr(32'h1000_FFFF, 0, 1'b1, 0);     // beq -1 taken at 8 -> 8
      do_instr(32'h1000_FFFF, 0, 1'b0, 0);     // not taken -> 12
      do_instr(32'hAC41_0000, 0, 1'b0, 0);     // sw -> 16
      for (int i = 0; i < 4; i++) do_instr(rops[i], int'($urandom_range(0, 2)), 1'b0, 0);
      do_instr(32'h1000_0003, 1, 1'b1, 0);     // beq +3 taken

      // Illegal opcode halts and stays halted with run held
      do_instr(32'hFC00_0000, 0, 1'b0, 0);
      run = 1'b1; bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (obs_req || obs_ctl != 6'h0) bad++;
      end
      check_val("halt_flag", {31'h0, obs_halt}, 32'h1);
      check_val("halt_quiet", bad, 0);
      check_val("halt_pc", obs_pc, mpc[0]);
      check_val("halt_ret", {16'h0, obs_ret}, {16'h0, mret[0]});
      run = 1'b0;
      rst_a_n = 1'b0;
      @(negedge clk);
      check_val("halt_clr", {31'h0, obs_halt}, 32'h0);
      check_val("halt_rst_pc", obs_pc, 32'h0);
      rst_a_n = 1'b1;
      mpc[0] = 32'h0; mret[0] = 16'h0;

      // Second instance: pc wrap and reset during the MEM phase of sw
      sel = 1'b1;
      @(negedge clk);
      check_val("wrap_rst_pc", obs_pc, 32'hFFFF_FFFC);
      do_instr(32'h0043_0820, 0, 1'b0, 0);
      check_val("wrap_pc", obs_pc, 32'h0);
      do_instr(32'hAC41_0000, 0, 1'b0, 3);
      repeat (3) @(negedge clk);
      check_val("post_abort_req", {31'h0, obs_req}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mc_control_seq.md
# mc_control_seq

Multi-cycle instruction sequencer and control unit sitting directly upstream of the register-file/ALU/data-memory datapath. Owns the PC, fetches one 32-bit word per instruction from instruction memory over a req/ack handshake, latches it into an instruction register and drives the datapath control set (RegDst, RegWrite, ALUSrc, ALUcontrol, MemWrite, MemRead, MemToReg) one phase at a time, so register-file and memory writes happen in exactly one cycle per instruction.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = keep issuing instructions, 0 = stop at next instruction boundary
- imem_addr  out  32  fetch address (= pc)
- imem_req  out  1  fetch request, held until ack
- imem_ack  in  1  fetch complete; imem_rdata valid in the same cycle
- imem_rdata  in  32  fetched instruction word
- zero  in  1  ALU zero flag from the datapath, sampled in EXEC for beq
- instruction  out  32  instruction register (IR) to the datapath
- pc  out  32  current PC
- RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg  out  1 each  datapath controls
- ALUcontrol  out  4  ALU operation select
- halted  out  1  sticky: illegal instruction seen
- retired  out  16  retired-instruction counter, wraps

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Reset state IDLE.
- IDLE: run=1 -> FETCH next cycle; else stay.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: IR <= imem_rdata, -> DECODE. No ack: stay, req held.
- DECODE (by IR[31:26], funct IR[5:0]): opcode 0x00 funct 0x20/0x22/0x24/0x25/0x2A, 0x23 lw, 0x2B sw, 0x04 beq -> EXEC. Anything else -> HALT, halted<=1, IR and pc unchanged.
- ALUcontrol: add 0101, sub 0110, and 0000, or 0001, slt 0111; lw/sw use 0101; beq uses 0110.
- EXEC: R-type -> WB; lw/sw -> MEM; beq -> boundary.
- MEM: lw -> WB; sw -> boundary.
- WB -> boundary.
- Boundary (end of last phase): pc updated, retired+1; then run=1 -> FETCH, run=0 -> IDLE.
- PC update: pc+4 normally; beq with zero=1 in EXEC: pc+4+(sign_extend(IR[15:0])<<2). All arithmetic modulo 2^32 (wrap at 32'hFFFF_FFFC+4 -> 0).
- Control outputs (combinational from state and IR):
  - IDLE/FETCH/HALT: all controls 0, ALUcontrol 0000.
  - DECODE onward, stable until boundary: RegDst=1 R-type else 0; ALUSrc=1 lw/sw else 0; MemToReg=1 lw else 0.
  - RegWrite=1 only in WB (R-type, lw). MemWrite=1 only in MEM for sw. MemRead=1 in MEM and WB for lw.
- HALT: sticky until rst_n; run ignored; imem_req=0.
- run deasserted mid-instruction: instruction completes, then IDLE.

## Timing
- Reset (async, rst_n=0): pc=RESET_PC, IR=0, state IDLE, imem_req=0, halted=0, retired=0, all controls 0. Reset mid-fetch or mid-instruction abandons it; no write enable asserts after rst_n falls.
- Cycles per instruction with same-cycle ack (FETCH counted once): beq 3, R-type 4, sw 4, lw 5. Each extra ack wait adds 1.
- IDLE->FETCH costs 1 cycle after run rises.
- pc and retired change on the clock edge that leaves the last phase; next FETCH presents new pc in the following cycle.
- imem_rdata sampled only on ack while in FETCH; ack outside FETCH ignored.
- Exactly one RegWrite or MemWrite cycle per retiring write instruction; zero for beq.

## Test plan
- Reset/idle: rst_n=0 then 1, run=0 for 10 cycles -> pc=0, imem_req=0, all controls 0, retired=0.
- add $1,$2,$3 (32'h0043_0820), ack same cycle -> RegDst=1, ALUcontrol=0101, RegWrite=1 for exactly one cycle (WB), pc=4, retired=1 after 4 cycles.
- lw $4,0($2) (32'h8C44_0000) with ack delayed 2 cycles -> imem_req held 3 cycles, MemRead=1 in MEM+WB, MemToReg=1, ALUSrc=1, RegWrite 1 cycle, 7 cycles total.
- sw $1,0($2) (32'hAC41_0000) -> MemWrite=1 one cycle, RegWrite never 1, 4 cycles; beq imm=-1 with zero=1 at pc=8 -> pc=8; zero=0 -> pc=12.
- Illegal opcode 0x3F -> halted=1, pc unchanged, no write enable, stays HALT with run=1; rst_n pulse clears.
- Wrap/mid-reset: RESET_PC=32'hFFFF_FFFC, one add -> pc=0; rst_n low during MEM of sw -> MemWrite never asserts, state IDLE.
